// File: rtl/seg7_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Function : multiplexed common-cathode 7-segment scanner with hex decode,
//             leading-zero suppression, blanking slot and frame-synced load.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 1,
  parameter int BLANK_CYC   = 0,
  parameter int LZ_SUPPRESS = 1,
  localparam int DIGIT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic                      load,
  output logic [7:0]                seg_data,
  output logic [NUM_DIGITS-1:0]     seg_com,
  output logic [DIGIT_W-1:0]        digit_idx,
  output logic                      frame_done
);

  localparam int c_SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [c_SLOT_W-1:0]       slot_cnt_q,     slot_cnt_d;
  logic [DIGIT_W-1:0]        digit_cnt_q,    digit_cnt_d;
  logic [4*NUM_DIGITS-1:0]   shadow_value_q, shadow_value_d;
  logic [NUM_DIGITS-1:0]     shadow_dp_q,    shadow_dp_d;
  logic [NUM_DIGITS-1:0]     shadow_blank_q, shadow_blank_d;
  logic                      load_pending_q, load_pending_d;
  logic [7:0]                seg_data_q,     seg_data_d;
  logic [NUM_DIGITS-1:0]     seg_com_q,      seg_com_d;
  logic [DIGIT_W-1:0]        digit_idx_q,    digit_idx_d;
  logic                      frame_done_q,   frame_done_d;

  logic                      w_slot_last;
  logic                      w_digit_last;
  logic                      w_frame_wrap;
  logic                      w_in_blank;
  logic [NUM_DIGITS-1:0]     w_suppress;
  logic [3:0]                w_cur_nib;
  logic                      w_cur_dp;
  logic                      w_cur_dark;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 8'hFC;
      4'h1:    hex_to_seg = 8'h60;
      4'h2:    hex_to_seg = 8'hDA;
      4'h3:    hex_to_seg = 8'hF2;
      4'h4:    hex_to_seg = 8'h66;
      4'h5:    hex_to_seg = 8'hB6;
      4'h6:    hex_to_seg = 8'hBE;
      4'h7:    hex_to_seg = 8'hE0;
      4'h8:    hex_to_seg = 8'hFE;
      4'h9:    hex_to_seg = 8'hF6;
      4'hA:    hex_to_seg = 8'hEE;
      4'hB:    hex_to_seg = 8'h3E;
      4'hC:    hex_to_seg = 8'h9C;
      4'hD:    hex_to_seg = 8'h7A;
      4'hE:    hex_to_seg = 8'h9E;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  assign w_slot_last  = (slot_cnt_q == c_SLOT_W'(SCAN_DIV - 1));
  assign w_digit_last = (digit_cnt_q == DIGIT_W'(NUM_DIGITS - 1));
  assign w_frame_wrap = w_slot_last && w_digit_last;
  assign w_in_blank   = (int'(slot_cnt_q) < BLANK_CYC);

  // A digit is a leading zero while it and every digit above it show nothing.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    w_suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow_value_q[4*i +: 4] == 4'h0) && !shadow_dp_q[i];
      w_suppress[i] = (LZ_SUPPRESS != 0) && (i != 0) && zero_run;
    end
  end

  always_comb begin
    w_cur_nib  = 4'h0;
    w_cur_dp   = 1'b0;
    w_cur_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_cnt_q == DIGIT_W'(i)) begin
        w_cur_nib  = shadow_value_q[4*i +: 4];
        w_cur_dp   = shadow_dp_q[i];
        w_cur_dark = shadow_blank_q[i] || w_suppress[i];
      end
    end
  end

  always_comb begin
    slot_cnt_d     = slot_cnt_q;
    digit_cnt_d    = digit_cnt_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    load_pending_d = load_pending_q;
    seg_data_d     = 8'h00;
    seg_com_d      = '1;
    digit_idx_d    = '0;
    frame_done_d   = 1'b0;

    if (!en) begin
      // Scan halted: the display is dark, so a load may land immediately.
      slot_cnt_d     = '0;
      digit_cnt_d    = '0;
      load_pending_d = 1'b0;
      if (load || load_pending_q) begin
        shadow_value_d = value;
        shadow_dp_d    = dp;
        shadow_blank_d = blank;
      end
    end else begin
      digit_idx_d  = digit_cnt_q;
      frame_done_d = w_frame_wrap;
      if (!w_in_blank) begin
        seg_com_d  = ~(NUM_DIGITS'(1) << digit_cnt_q);
        seg_data_d = w_cur_dark ? 8'h00 : (hex_to_seg(w_cur_nib) | {7'b0, w_cur_dp});
      end

      if (w_slot_last) begin
        slot_cnt_d  = '0;
        digit_cnt_d = w_digit_last ? '0 : digit_cnt_q + DIGIT_W'(1);
      end else begin
        slot_cnt_d  = slot_cnt_q + c_SLOT_W'(1);
      end

      // Shadow only swaps at the frame boundary so a frame is never torn.
      if (w_frame_wrap) begin
        load_pending_d = 1'b0;
        if (load || load_pending_q) begin
          shadow_value_d = value;
          shadow_dp_d    = dp;
          shadow_blank_d = blank;
        end
      end else if (load) begin
        load_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q     <= '0;
      digit_cnt_q    <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      load_pending_q <= 1'b0;
      seg_data_q     <= 8'h00;
      seg_com_q      <= '1;
      digit_idx_q    <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      digit_cnt_q    <= digit_cnt_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      load_pending_q <= load_pending_d;
      seg_data_q     <= seg_data_d;
      seg_com_q      <= seg_com_d;
      digit_idx_q    <= digit_idx_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign seg_data   = seg_data_q;
  assign seg_com    = seg_com_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Function : directed self-checking bench for seg7_scan_ctrl (two configs).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 digits, 1 cycle per slot, no blanking slot, zero suppression.
  logic        rst_a, en_a, load_a;
  logic [15:0] value_a;
  logic [3:0]  dp_a, blank_a;
  logic [7:0]  seg_data_a;
  logic [3:0]  seg_com_a;
  logic [1:0]  digit_idx_a;
  logic        frame_done_a;

  // Instance B: 4 digits, 3 cycles per slot, 1 blanking cycle, zero suppression.
  logic        rst_b, en_b, load_b;
  logic [15:0] value_b;
  logic [3:0]  dp_b, blank_b;
  logic [7:0]  seg_data_b;
  logic [3:0]  seg_com_b;
  logic [1:0]  digit_idx_b;
  logic        frame_done_b;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(1), .BLANK_CYC(0), .LZ_SUPPRESS(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .value(value_a), .dp(dp_a), .blank(blank_a),
    .load(load_a), .seg_data(seg_data_a), .seg_com(seg_com_a), .digit_idx(digit_idx_a),
    .frame_done(frame_done_a)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(3), .BLANK_CYC(1), .LZ_SUPPRESS(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .value(value_b), .dp(dp_b), .blank(blank_b),
    .load(load_b), .seg_data(seg_data_b), .seg_com(seg_com_b), .digit_idx(digit_idx_b),
    .frame_done(frame_done_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic edge_a(input string tag, input logic [7:0] exp_seg, input int digit,
                        input logic exp_fd);
    logic [3:0] exp_com;
    logic [1:0] exp_idx;
    exp_com = ~(4'b0001 << digit);
    exp_idx = digit[1:0];
    @(posedge clk); #1;
    chk({tag, ".seg"}, {24'h0, seg_data_a}, {24'h0, exp_seg});
    chk({tag, ".com"}, {28'h0, seg_com_a}, {28'h0, exp_com});
    chk({tag, ".idx"}, {30'h0, digit_idx_a}, {30'h0, exp_idx});
    chk({tag, ".fd"},  {31'h0, frame_done_a}, {31'h0, exp_fd});
  endtask

  task automatic dark_a(input string tag);
    @(posedge clk); #1;
    chk({tag, ".seg"}, {24'h0, seg_data_a}, 32'h00);
    chk({tag, ".com"}, {28'h0, seg_com_a}, 32'hF);
    chk({tag, ".idx"}, {30'h0, digit_idx_a}, 32'h0);
    chk({tag, ".fd"},  {31'h0, frame_done_a}, 32'h0);
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0; load_a = 1'b0; value_a = '0; dp_a = '0; blank_a = '0;
    rst_b = 1'b0; en_b = 1'b0; load_b = 1'b0; value_b = '0; dp_b = '0; blank_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a.seg", {24'h0, seg_data_a}, 32'h00);
    chk("rst_a.com", {28'h0, seg_com_a}, 32'hF);
    chk("rst_a.idx", {30'h0, digit_idx_a}, 32'h0);
    chk("rst_a.fd",  {31'h0, frame_done_a}, 32'h0);
    chk("rst_b.seg", {24'h0, seg_data_b}, 32'h00);
    chk("rst_b.com", {28'h0, seg_com_b}, 32'hF);

    // Blanking slot plus zero suppression on an all-zero display.
    rst_b = 1'b1; en_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int         d;
      int         s;
      logic [3:0] ec;
      logic [7:0] es;
      d  = k / 3;
      s  = k % 3;
      ec = (s == 0) ? 4'hF : ~(4'b0001 << d);
      es = (s != 0 && d == 0) ? 8'hFC : 8'h00;
      @(posedge clk); #1;
      chk($sformatf("t2.k%0d.seg", k), {24'h0, seg_data_b}, {24'h0, es});
      chk($sformatf("t2.k%0d.com", k), {28'h0, seg_com_b}, {28'h0, ec});
      chk($sformatf("t2.k%0d.fd", k), {31'h0, frame_done_b}, {31'h0, (k == 11)});
      if (s != 0) chk($sformatf("t2.k%0d.idx", k), {30'h0, digit_idx_b}, d);
    end
    en_b = 1'b0;

    // Load during the first frame lands at the frame wrap.
    rst_a = 1'b1; en_a = 1'b1; value_a = 16'h12AF; load_a = 1'b1;
    edge_a("t1.f0d0", 8'hFC, 0, 1'b0);
    load_a = 1'b0;
    edge_a("t1.f0d1", 8'h00, 1, 1'b0);
    edge_a("t1.f0d2", 8'h00, 2, 1'b0);
    edge_a("t1.f0d3", 8'h00, 3, 1'b1);
    edge_a("t1.f1d0", 8'h8E, 0, 1'b0);
    edge_a("t1.f1d1", 8'hEE, 1, 1'b0);
    edge_a("t1.f1d2", 8'hDA, 2, 1'b0);
    edge_a("t1.f1d3", 8'h60, 3, 1'b1);

    // Leading-zero suppression, then a decimal point keeps the top digit lit.
    value_a = 16'h0405; load_a = 1'b1;
    edge_a("t3.f0d0", 8'h8E, 0, 1'b0);
    load_a = 1'b0;
    edge_a("t3.f0d1", 8'hEE, 1, 1'b0);
    edge_a("t3.f0d2", 8'hDA, 2, 1'b0);
    edge_a("t3.f0d3", 8'h60, 3, 1'b1);
    edge_a("t3.f1d0", 8'hB6, 0, 1'b0);
    edge_a("t3.f1d1", 8'hFC, 1, 1'b0);
    edge_a("t3.f1d2", 8'h66, 2, 1'b0);
    edge_a("t3.f1d3", 8'h00, 3, 1'b1);
    dp_a = 4'b1000; load_a = 1'b1;
    edge_a("t3.f2d0", 8'hB6, 0, 1'b0);
    load_a = 1'b0;
    edge_a("t3.f2d1", 8'hFC, 1, 1'b0);
    edge_a("t3.f2d2", 8'h66, 2, 1'b0);
    edge_a("t3.f2d3", 8'h00, 3, 1'b1);
    edge_a("t3.f3d0", 8'hB6, 0, 1'b0);
    edge_a("t3.f3d1", 8'hFC, 1, 1'b0);
    edge_a("t3.f3d2", 8'h66, 2, 1'b0);
    edge_a("t3.f3d3", 8'hFD, 3, 1'b1);

    // Mid-frame load shows old digits until the next frame.
    edge_a("t4.f0d0", 8'hB6, 0, 1'b0);
    value_a = 16'h3210; dp_a = 4'b0000; load_a = 1'b1;
    edge_a("t4.f0d1", 8'hFC, 1, 1'b0);
    load_a = 1'b0;
    edge_a("t4.f0d2", 8'h66, 2, 1'b0);
    edge_a("t4.f0d3", 8'hFD, 3, 1'b1);
    edge_a("t4.f1d0", 8'hFC, 0, 1'b0);
    edge_a("t4.f1d1", 8'h60, 1, 1'b0);
    edge_a("t4.f1d2", 8'hDA, 2, 1'b0);
    // Load on the frame_done cycle is captured on that same edge.
    value_a = 16'h8888; blank_a = 4'b0010; load_a = 1'b1;
    edge_a("t4.f1d3", 8'hF2, 3, 1'b1);
    load_a = 1'b0;

    // Forced blank on digit 1.
    edge_a("t5.d0", 8'hFE, 0, 1'b0);
    edge_a("t5.d1", 8'h00, 1, 1'b0);
    edge_a("t5.d2", 8'hFE, 2, 1'b0);

    // Asynchronous reset mid-frame.
    #2 rst_a = 1'b0;
    #1;
    chk("t6.arst.seg", {24'h0, seg_data_a}, 32'h00);
    chk("t6.arst.com", {28'h0, seg_com_a}, 32'hF);
    chk("t6.arst.fd",  {31'h0, frame_done_a}, 32'h0);
    #1 rst_a = 1'b1;
    edge_a("t6.rel.d0", 8'hFC, 0, 1'b0);
    edge_a("t6.rel.d1", 8'h00, 1, 1'b0);

    // Scan disabled for five cycles; the last one loads directly.
    en_a = 1'b0;
    dark_a("t6.en0.c0");
    dark_a("t6.en0.c1");
    dark_a("t6.en0.c2");
    dark_a("t6.en0.c3");
    value_a = 16'h0405; dp_a = 4'b0000; blank_a = 4'b0000; load_a = 1'b1;
    dark_a("t6.en0.c4");
    load_a = 1'b0; en_a = 1'b1;
    edge_a("t6.run.d0", 8'hB6, 0, 1'b0);
    edge_a("t6.run.d1", 8'hFC, 1, 1'b0);
    edge_a("t6.run.d2", 8'h66, 2, 1'b0);
    edge_a("t6.run.d3", 8'h00, 3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller; successor to the fixed 8-digit display driver. Drives NUM_DIGITS common-cathode digits with:
- full 0-F hex decode
- per-digit decimal point and forced blank
- leading-zero suppression
- programmable scan prescaler
- anti-ghost blanking slot
- frame-synchronous double-buffered value load (no tearing)
Sits between the Miller-Rabin result/status registers and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16).
SCAN_DIV, 1, clk cycles per digit slot (>=1).
BLANK_CYC, 0, leading cycles of each slot with all digits off (0..SCAN_DIV-1).
LZ_SUPPRESS, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
en  in  1  scan enable.
value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i].
dp  in  NUM_DIGITS  decimal point per digit.
blank  in  NUM_DIGITS  force digit i dark.
load  in  1  request shadow update of value/dp/blank.
seg_data  out  8  {a,b,c,d,e,f,g,dp}, active-high.
seg_com  out  NUM_DIGITS  digit select, active-low one-cold.
digit_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently driven.
frame_done  out  1  one-cycle pulse on last slot of frame.

Behaviour:
- Reset (rst=0, async): slot_cnt=0, digit_cnt=0, shadow value/dp/blank=0, load_pending=0. Outputs: seg_data=0, seg_com=all 1s, digit_idx=0, frame_done=0.
- Outputs are registered. On each edge with en=1, outputs reflect the current (digit_cnt, slot_cnt); then the counters advance. The first edge after reset release drives digit 0.
- Counter advance: slot_cnt increments to SCAN_DIV-1, then wraps to 0 and digit_cnt increments. digit_cnt wraps from NUM_DIGITS-1 to 0.
- Blanking: when slot_cnt < BLANK_CYC, seg_com=all 1s and seg_data=0.
- Otherwise: seg_com has bit digit_cnt = 0 and all other bits 1. digit_idx = digit_cnt.
- Decode table: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, B 3E, C 9C, D 7A, E 9E, F 8E. Shadow dp[i] is ORed into bit0.
- Digit dark (seg_data=0, seg_com still selects it) if shadow blank[i]=1, or if suppressed.
- Suppression (LZ_SUPPRESS=1): digit i>0 is suppressed when it and every higher digit have nibble 0 and dp 0. Digit 0 is never suppressed.
- frame_done=1 for exactly one cycle, coincident with the output of digit NUM_DIGITS-1, slot SCAN_DIV-1.
- load: sets load_pending. On the frame-wrap edge (the same edge that outputs frame_done):
  - if load_pending or load is 1, capture shadow from value/dp/blank as sampled on that edge, and clear load_pending;
  - otherwise the shadow holds.
- Shadow changes only at frame boundaries while en=1, so the displayed frame is always coherent.
- en=0 (synchronous):
  - counters clear to 0; outputs go to the reset values;
  - load captures the shadow directly on the same edge; no pending state is left.
  - After en returns to 1, the next edge drives digit 0, slot 0.
- Async reset mid-frame: immediate return to reset state; any pending load is discarded.

Test Plan:
1. NUM_DIGITS=4, SCAN_DIV=1, BLANK_CYC=0, LZ_SUPPRESS=0; load value=16'h12AF one cycle, en=1 -> after first frame, seg_com cycles E,D,B,7 with seg_data 8E,EE,DA,60 per cycle; frame_done pulses every 4th cycle.
2. NUM_DIGITS=4, SCAN_DIV=3, BLANK_CYC=1; value=16'h0000 loaded -> each digit shows 1 cycle seg_com=F, then 2 cycles selected. With LZ_SUPPRESS=1, only digit 0 shows FC; digits 1-3 show 00.
3. LZ_SUPPRESS=1, value=16'h0405, dp=4'b0000 -> digit3 dark; digits 2,1,0 = 66,FC,B6. Then dp=4'b1000 loaded -> digit3 = FD.
4. Change value mid-frame with load=1 at digit 1 -> remaining digits of the current frame show old value; new value appears from digit 0 of next frame. load asserted on the frame_done cycle -> captured on that edge.
5. blank=4'b0010 with value=16'h8888 -> digit1 seg_data=00 while digits 0,2,3 = FE.
6. Assert rst low at digit 2 -> outputs immediately seg_data=00, seg_com=all 1s, frame_done=0. After release, first edge drives digit 0 with shadow=0. en=0 for 5 cycles -> outputs stay blank; then restart at digit 0.
